// File: rtl/ndata_width_converter_pkg.sv
// Shared stream helpers for the ndata width converter.
// Lane ratio and downsize slice counting.
package libstf_pkg;

  localparam int MAX_KEEP = 256;

  typedef logic [MAX_KEEP-1:0] keep_w_t;

  typedef enum logic [1:0] {
    MODE_EQUAL,
    MODE_UP,
    MODE_DOWN
  } mode_e;

  function automatic int ratio(
    input int a,
    input int b
  );
    return (a > b) ? a / b : b / a;
  endfunction

  // Index of the highest slice holding a kept lane, -1 when none.
  function automatic int highest_set_slice(
    input keep_w_t keep,
    input int      slice_width
  );
    int r;
    r = -1;
    for (int i = 0; i < MAX_KEEP; i++) begin
      if (keep[i]) r = i / slice_width;
    end
    return r;
  endfunction

endpackage

// File: rtl/ndata_width_converter_if.sv
// Multi-lane stream bundle: data/keep per lane plus last and
// a valid/ready handshake.
interface ndata_i #(
  parameter type data_t       = logic [31:0],
  parameter int  NUM_ELEMENTS = 4
);

  data_t [NUM_ELEMENTS-1:0] data;
  logic  [NUM_ELEMENTS-1:0] keep;
  logic                     last;
  logic                     valid;
  logic                     ready;

  modport m (
    output data, keep, last, valid,
    input  ready
  );

  modport s (
    input  data, keep, last, valid,
    output ready
  );

endinterface

// File: rtl/ndata_width_converter_reg.sv
// One-stage ready/valid register for an ndata stream,
// full throughput when the sink keeps ready high.
module ndata_reg #(
  parameter type data_t   = logic [31:0],
  parameter int  ELEMENTS = 4
) (
  input logic clk,
  input logic rst,
  ndata_i.s   in,
  ndata_i.m   out
);

  data_t [ELEMENTS-1:0] data_q, data_d;
  logic  [ELEMENTS-1:0] keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;

  assign in.ready = !rst && (!valid_q || out.ready);

  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (in.valid && in.ready) begin
      data_d  = in.data;
      keep_d  = in.keep;
      last_d  = in.last;
      valid_d = 1'b1;
    end else if (out.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out.data  = data_q;
  assign out.keep  = keep_q;
  assign out.last  = last_q;
  assign out.valid = valid_q;

endmodule

// File: rtl/ndata_width_converter.sv
// Lane-count converter for ndata streams: packs narrow beats into
// wide ones or slices wide beats into narrow ones.
module ndata_width_converter
  import libstf_pkg::*;
#(
  parameter type data_t       = logic [31:0],
  parameter int  IN_ELEMENTS  = 4,
  parameter int  OUT_ELEMENTS = 4
) (
  input logic clk,
  input logic rst,
  ndata_i.s   in,
  ndata_i.m   out
);

  localparam mode_e MODE =
    (IN_ELEMENTS == OUT_ELEMENTS) ? MODE_EQUAL :
    (OUT_ELEMENTS > IN_ELEMENTS)  ? MODE_UP    :
                                    MODE_DOWN;

  if ((IN_ELEMENTS < 1) || (OUT_ELEMENTS < 1) ||
      ((IN_ELEMENTS % OUT_ELEMENTS != 0) &&
       (OUT_ELEMENTS % IN_ELEMENTS != 0))) begin : g_bad_ratio
    $error("ndata_width_converter: lane counts must divide");
  end

  if (MODE == MODE_EQUAL) begin : g_eq

    ndata_reg #(
      .data_t  (data_t),
      .ELEMENTS(OUT_ELEMENTS)
    ) u_reg (
      .clk(clk),
      .rst(rst),
      .in (in),
      .out(out)
    );

  end else if (MODE == MODE_UP) begin : g_up

    localparam int RATIO = ratio(IN_ELEMENTS, OUT_ELEMENTS);
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    ndata_i #(
      .data_t      (data_t),
      .NUM_ELEMENTS(OUT_ELEMENTS)
    ) stage_if ();

    data_t [OUT_ELEMENTS-1:0] stg_data_q, stg_data_d, mdata;
    logic  [OUT_ELEMENTS-1:0] stg_keep_q, stg_keep_d, mkeep;
    logic                     stg_last_q, stg_last_d;
    logic                     full_q, full_d;
    logic  [CW-1:0]           s_q, s_d;
    logic                     acc, done;

    // full_q: staging holds a finished beat the output stage refused.
    assign in.ready = !rst && (!full_q || stage_if.ready);
    assign acc      = in.valid && in.ready;
    assign done     = acc && (in.last || (s_q == CW'(RATIO - 1)));

    always_comb begin
      mdata = full_q ? '0 : stg_data_q;
      mkeep = full_q ? '0 : stg_keep_q;
      mdata[int'(s_q) * IN_ELEMENTS +: IN_ELEMENTS] = in.data;
      mkeep[int'(s_q) * IN_ELEMENTS +: IN_ELEMENTS] = in.keep;

      stage_if.valid = full_q || done;
      stage_if.data  = full_q ? stg_data_q : mdata;
      stage_if.keep  = full_q ? stg_keep_q : mkeep;
      stage_if.last  = full_q ? stg_last_q : in.last;

      stg_data_d = stg_data_q;
      stg_keep_d = stg_keep_q;
      stg_last_d = stg_last_q;
      full_d     = full_q;
      s_d        = s_q;

      if (full_q && stage_if.ready) begin
        full_d     = 1'b0;
        stg_data_d = '0;
        stg_keep_d = '0;
        stg_last_d = 1'b0;
      end

      if (acc) begin
        if (done) begin
          s_d = '0;
          if (full_q || !stage_if.ready) begin
            full_d     = 1'b1;
            stg_data_d = mdata;
            stg_keep_d = mkeep;
            stg_last_d = in.last;
          end else begin
            stg_data_d = '0;
            stg_keep_d = '0;
            stg_last_d = 1'b0;
          end
        end else begin
          s_d        = s_q + 1'b1;
          stg_data_d = mdata;
          stg_keep_d = mkeep;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stg_data_q <= '0;
        stg_keep_q <= '0;
        stg_last_q <= 1'b0;
        full_q     <= 1'b0;
        s_q        <= '0;
      end else begin
        stg_data_q <= stg_data_d;
        stg_keep_q <= stg_keep_d;
        stg_last_q <= stg_last_d;
        full_q     <= full_d;
        s_q        <= s_d;
      end
    end

    ndata_reg #(
      .data_t  (data_t),
      .ELEMENTS(OUT_ELEMENTS)
    ) u_out_reg (
      .clk(clk),
      .rst(rst),
      .in (stage_if),
      .out(out)
    );

  end else begin : g_dn

    localparam int RATIO = ratio(IN_ELEMENTS, OUT_ELEMENTS);
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    data_t [IN_ELEMENTS-1:0] hold_data_q, hold_data_d;
    logic  [IN_ELEMENTS-1:0] hold_keep_q, hold_keep_d;
    logic                    hold_last_q, hold_last_d;
    logic                    held_q, held_d;
    logic  [CW-1:0]          k_q, k_d;
    logic  [CW-1:0]          n_q, n_d;
    logic                    fin, acc;
    int                      hs;

    // n_q holds the index of the final slice to emit.
    assign fin       = held_q && out.ready && (k_q == n_q);
    assign in.ready  = !rst && (!held_q || fin);
    assign acc       = in.valid && in.ready;

    assign out.valid = held_q;
    assign out.data  = hold_data_q[int'(k_q) * OUT_ELEMENTS +: OUT_ELEMENTS];
    assign out.keep  = hold_keep_q[int'(k_q) * OUT_ELEMENTS +: OUT_ELEMENTS];
    assign out.last  = held_q && hold_last_q && (k_q == n_q);

    always_comb begin
      hs          = highest_set_slice(keep_w_t'(in.keep), OUT_ELEMENTS);
      hold_data_d = hold_data_q;
      hold_keep_d = hold_keep_q;
      hold_last_d = hold_last_q;
      held_d      = held_q;
      k_d         = k_q;
      n_d         = n_q;
      if (acc) begin
        hold_data_d = in.data;
        hold_keep_d = in.keep;
        hold_last_d = in.last;
        held_d      = 1'b1;
        k_d         = '0;
        n_d         = (hs > 0) ? CW'(hs) : '0;
      end else if (fin) begin
        held_d = 1'b0;
        k_d    = '0;
      end else if (held_q && out.ready) begin
        k_d = k_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_data_q <= '0;
        hold_keep_q <= '0;
        hold_last_q <= 1'b0;
        held_q      <= 1'b0;
        k_q         <= '0;
        n_q         <= '0;
      end else begin
        hold_data_q <= hold_data_d;
        hold_keep_q <= hold_keep_d;
        hold_last_q <= hold_last_d;
        held_q      <= held_d;
        k_q         <= k_d;
        n_q         <= n_d;
      end
    end

  end

endmodule

// File: tb/tb_ndata_width_converter.sv
// Directed bench for ndata_width_converter in upsize 2->8,
// downsize 8->2 and equal 4->4 configurations.
`define CHK(tag, o, e) chk(tag, 256'(o), 256'(e))

module tb_ndata_width_converter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ndata_i #(.data_t(logic [31:0]), .NUM_ELEMENTS(2)) up_in ();
  ndata_i #(.data_t(logic [31:0]), .NUM_ELEMENTS(8)) up_out ();
  ndata_i #(.data_t(logic [31:0]), .NUM_ELEMENTS(8)) dn_in ();
  ndata_i #(.data_t(logic [31:0]), .NUM_ELEMENTS(2)) dn_out ();
  ndata_i #(.data_t(logic [31:0]), .NUM_ELEMENTS(4)) eq_in ();
  ndata_i #(.data_t(logic [31:0]), .NUM_ELEMENTS(4)) eq_out ();

  ndata_width_converter #(
    .data_t(logic [31:0]), .IN_ELEMENTS(2), .OUT_ELEMENTS(8)
  ) u_up (.clk(clk), .rst(rst), .in(up_in), .out(up_out));

  ndata_width_converter #(
    .data_t(logic [31:0]), .IN_ELEMENTS(8), .OUT_ELEMENTS(2)
  ) u_dn (.clk(clk), .rst(rst), .in(dn_in), .out(dn_out));

  ndata_width_converter #(
    .data_t(logic [31:0]), .IN_ELEMENTS(4), .OUT_ELEMENTS(4)
  ) u_eq (.clk(clk), .rst(rst), .in(eq_in), .out(eq_out));

  always #5 clk = ~clk;

  task automatic chk(
    input string          tag,
    input logic [255:0]   obs,
    input logic [255:0]   exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] lanes(input int s, input int n);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j*32 +: 32] = 32'(s + j);
    return r;
  endfunction

  task automatic up_send(
    input int         a,
    input int         b,
    input logic [1:0] k,
    input logic       l
  );
    @(negedge clk);
    up_in.valid   = 1'b1;
    up_in.data[0] = 32'(a);
    up_in.data[1] = 32'(b);
    up_in.keep    = k;
    up_in.last    = l;
    #1;
    for (int t = 0; t < 50 && !up_in.ready; t++) begin
      @(negedge clk);
      #1;
    end
    `CHK("up_send_ready", up_in.ready, 1'b1);
  endtask

  task automatic dn_send(
    input int         s,
    input logic [7:0] k,
    input logic       l
  );
    @(negedge clk);
    dn_in.valid = 1'b1;
    for (int j = 0; j < 8; j++) dn_in.data[j] = 32'(s + j);
    dn_in.keep = k;
    dn_in.last = l;
    #1;
    for (int t = 0; t < 50 && !dn_in.ready; t++) begin
      @(negedge clk);
      #1;
    end
    `CHK("dn_send_ready", dn_in.ready, 1'b1);
  endtask

  logic [127:0] ed, pd;
  logic [3:0]   ek, pk;
  logic         el, pl;
  logic         held, er;
  int           beat, kk, cur, got;

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    up_in.valid = 1'b0; up_in.data = '0; up_in.keep = '0; up_in.last = 1'b0;
    dn_in.valid = 1'b0; dn_in.data = '0; dn_in.keep = '0; dn_in.last = 1'b0;
    eq_in.valid = 1'b0; eq_in.data = '0; eq_in.keep = '0; eq_in.last = 1'b0;
    up_out.ready = 1'b0;
    dn_out.ready = 1'b0;
    eq_out.ready = 1'b0;
    #2;
    `CHK("rst_up_valid", up_out.valid, 1'b0);
    `CHK("rst_up_data", up_out.data, 0);
    `CHK("rst_up_keep", up_out.keep, 8'h00);
    `CHK("rst_up_last", up_out.last, 1'b0);
    `CHK("rst_up_ready", up_in.ready, 1'b0);
    `CHK("rst_dn_valid", dn_out.valid, 1'b0);
    `CHK("rst_dn_data", dn_out.data, 0);
    `CHK("rst_dn_ready", dn_in.ready, 1'b0);
    `CHK("rst_eq_valid", eq_out.valid, 1'b0);
    `CHK("rst_eq_ready", eq_in.ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    `CHK("post_rst_up_ready", up_in.ready, 1'b1);
    `CHK("post_rst_dn_ready", dn_in.ready, 1'b1);
    `CHK("post_rst_eq_ready", eq_in.ready, 1'b1);
    up_out.ready = 1'b1;
    dn_out.ready = 1'b1;
    eq_out.ready = 1'b1;

    up_send(1, 2, 2'b11, 1'b0);
    up_send(3, 4, 2'b11, 1'b0);
    up_send(5, 6, 2'b11, 1'b0);
    up_send(7, 8, 2'b11, 1'b1);
    `CHK("up_full_early_valid", up_out.valid, 1'b0);
    @(negedge clk);
    up_in.valid = 1'b0;
    #1;
    `CHK("up_full_valid", up_out.valid, 1'b1);
    `CHK("up_full_data", up_out.data, lanes(1, 8));
    `CHK("up_full_keep", up_out.keep, 8'hFF);
    `CHK("up_full_last", up_out.last, 1'b1);
    @(negedge clk);
    #1;
    `CHK("up_full_drained", up_out.valid, 1'b0);

    up_send(1, 2, 2'b11, 1'b0);
    up_send(3, 4, 2'b11, 1'b1);
    @(negedge clk);
    up_in.valid = 1'b0;
    #1;
    `CHK("up_part_valid", up_out.valid, 1'b1);
    `CHK("up_part_data", up_out.data, lanes(1, 4));
    `CHK("up_part_keep", up_out.keep, 8'h0F);
    `CHK("up_part_last", up_out.last, 1'b1);

    up_send(5, 6, 2'b11, 1'b1);
    @(negedge clk);
    up_in.valid = 1'b0;
    #1;
    `CHK("up_slot0_valid", up_out.valid, 1'b1);
    `CHK("up_slot0_data", up_out.data, lanes(5, 2));
    `CHK("up_slot0_keep", up_out.keep, 8'h03);
    `CHK("up_slot0_last", up_out.last, 1'b1);
    @(negedge clk);

    up_out.ready = 1'b0;
    for (int i = 0; i < 4; i++) up_send(21 + 2*i, 22 + 2*i, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) up_send(31 + 2*i, 32 + 2*i, 2'b11, i == 3);
    @(negedge clk);
    up_in.valid = 1'b0;
    #1;
    `CHK("up_stall_ready", up_in.ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      `CHK("up_stall_valid", up_out.valid, 1'b1);
      `CHK("up_stall_data_a", up_out.data, lanes(21, 8));
      `CHK("up_stall_last_a", up_out.last, 1'b0);
      @(negedge clk);
      #1;
    end
    up_out.ready = 1'b1;
    @(negedge clk);
    #1;
    `CHK("up_stall_valid_b", up_out.valid, 1'b1);
    `CHK("up_stall_data_b", up_out.data, lanes(31, 8));
    `CHK("up_stall_last_b", up_out.last, 1'b1);
    `CHK("up_stall_ready_b", up_in.ready, 1'b1);
    @(negedge clk);
    #1;
    `CHK("up_stall_drained", up_out.valid, 1'b0);

    up_send(1, 2, 2'b11, 1'b0);
    up_send(3, 4, 2'b11, 1'b0);
    @(negedge clk);
    up_in.valid = 1'b0;
    rst = 1'b1;
    #1;
    `CHK("up_midrst_valid", up_out.valid, 1'b0);
    `CHK("up_midrst_ready", up_in.ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) up_send(9 + 2*i, 10 + 2*i, 2'b11, 1'b0);
    @(negedge clk);
    up_in.valid = 1'b0;
    #1;
    `CHK("up_after_rst_valid", up_out.valid, 1'b1);
    `CHK("up_after_rst_data", up_out.data, lanes(9, 8));
    `CHK("up_after_rst_keep", up_out.keep, 8'hFF);
    `CHK("up_after_rst_last", up_out.last, 1'b0);
    checks++;
    if (256'(up_out.data) !== lanes(9, 8)) begin
      failures++;
      $error("FAIL up_after_rst_data2 observed=%0h", up_out.data);
    end
    @(negedge clk);

    dn_send(1, 8'h3F, 1'b1);
    @(negedge clk);
    dn_in.valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      `CHK("dn3_valid", dn_out.valid, 1'b1);
      `CHK("dn3_data", dn_out.data, lanes(1 + 2*k, 2));
      `CHK("dn3_keep", dn_out.keep, 2'b11);
      `CHK("dn3_last", dn_out.last, k == 2);
      @(negedge clk);
      #1;
    end
    `CHK("dn3_drained", dn_out.valid, 1'b0);

    dn_send(1, 8'h03, 1'b1);
    @(negedge clk);
    dn_in.valid = 1'b0;
    #1;
    `CHK("dn1_valid", dn_out.valid, 1'b1);
    `CHK("dn1_data", dn_out.data, lanes(1, 2));
    `CHK("dn1_last", dn_out.last, 1'b1);
    @(negedge clk);
    #1;
    `CHK("dn1_drained", dn_out.valid, 1'b0);

    dn_send(11, 8'h00, 1'b0);
    @(negedge clk);
    dn_in.valid = 1'b0;
    #1;
    `CHK("dn0_valid", dn_out.valid, 1'b1);
    `CHK("dn0_data", dn_out.data, lanes(11, 2));
    `CHK("dn0_keep", dn_out.keep, 2'b00);
    `CHK("dn0_last", dn_out.last, 1'b0);
    @(negedge clk);
    #1;
    `CHK("dn0_drained", dn_out.valid, 1'b0);

    held = 1'b0;
    beat = 0;
    kk   = 0;
    cur  = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      dn_out.ready = (cyc % 2) == 0;
      if (beat < 2) begin
        dn_in.valid = 1'b1;
        for (int j = 0; j < 8; j++)
          dn_in.data[j] = 32'(((beat == 0) ? 41 : 51) + j);
        dn_in.keep = 8'hFF;
        dn_in.last = beat == 1;
      end else begin
        dn_in.valid = 1'b0;
      end
      #1;
      er = !held || (dn_out.ready && kk == 3);
      `CHK("dn_tog_ready", dn_in.ready, er);
      `CHK("dn_tog_valid", dn_out.valid, held);
      if (held) begin
        `CHK("dn_tog_data", dn_out.data,
             lanes(((cur == 0) ? 41 : 51) + 2*kk, 2));
        `CHK("dn_tog_last", dn_out.last, (cur == 1) && (kk == 3));
      end
      if (held && dn_out.ready) begin
        got++;
        if (kk == 3) held = 1'b0;
        else kk++;
      end
      if (er && beat < 2) begin
        held = 1'b1;
        kk   = 0;
        cur  = beat;
        beat++;
      end
      if (beat == 2 && !held) break;
    end
    `CHK("dn_tog_count", got, 8);
    checks++;
    if (got != 8) begin
      failures++;
      $error("FAIL dn_tog_count2 observed=%0d", got);
    end
    @(negedge clk);
    dn_in.valid = 1'b0;
    #1;
    `CHK("dn_tog_drained", dn_out.valid, 1'b0);

    pd = '0;
    pk = '0;
    pl = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ed = {$urandom, $urandom, $urandom, $urandom};
      ek = 4'($urandom);
      el = 1'($urandom);
      eq_in.valid = 1'b1;
      eq_in.data  = ed;
      eq_in.keep  = ek;
      eq_in.last  = el;
      #1;
      `CHK("eq_ready", eq_in.ready, 1'b1);
      if (i > 0) begin
        `CHK("eq_valid", eq_out.valid, 1'b1);
        `CHK("eq_data", eq_out.data, pd);
        `CHK("eq_keep", eq_out.keep, pk);
        `CHK("eq_last", eq_out.last, pl);
        checks++;
        if (eq_out.data !== pd) begin
          failures++;
          $error("FAIL eq_data2 observed=%0h expected=%0h",
                 eq_out.data, pd);
        end
        checks++;
        if (eq_out.keep !== pk) begin
          failures++;
          $error("FAIL eq_keep2 observed=%0h expected=%0h",
                 eq_out.keep, pk);
        end
      end
      pd = ed;
      pk = ek;
      pl = el;
    end
    @(negedge clk);
    eq_in.valid = 1'b0;
    #1;
    `CHK("eq_final_valid", eq_out.valid, 1'b1);
    `CHK("eq_final_data", eq_out.data, pd);
    @(negedge clk);
    #1;
    `CHK("eq_drained", eq_out.valid, 1'b0);

    eq_out.ready = 1'b0;
    eq_in.valid  = 1'b1;
    eq_in.data   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    eq_in.keep   = 4'hF;
    eq_in.last   = 1'b0;
    #1;
    `CHK("eq_stall_ready0", eq_in.ready, 1'b1);
    @(negedge clk);
    eq_in.data = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    eq_in.last = 1'b1;
    #1;
    `CHK("eq_stall_ready1", eq_in.ready, 1'b0);
    `CHK("eq_stall_data", eq_out.data,
         128'h1111_2222_3333_4444_5555_6666_7777_8888);
    eq_out.ready = 1'b1;
    @(negedge clk);
    eq_in.valid = 1'b0;
    #1;
    `CHK("eq_stall_data2", eq_out.data,
         128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000);
    `CHK("eq_stall_last2", eq_out.last, 1'b1);
    @(negedge clk);
    #1;
    `CHK("eq_stall_drained", eq_out.valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
